// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states, instruction field positions and op predicates
package cpu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 1;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB} state_t;
  function automatic logic is_multi(input logic [2:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/cpu_sequencer_seq_timeout_ctr.sv
// seq_timeout_ctr: clearable enabled counter flagging its MAX-th counted cycle
module seq_timeout_ctr
  import cpu_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(MAX);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(MAX - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/exec/wait/writeback sequencer owning the program counter
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            instr_valid,
  input  logic [7:0]      instr,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rf_raddr_a,
  output logic [1:0]      rf_raddr_b,
  output logic [1:0]      rf_waddr,
  output logic            rf_we,
  output logic            flag_we,
  output logic [2:0]      alu_sel,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            busy,
  output logic            err
);
  state_t state, nxt;
  logic [7:0] ir;
  logic [2:0] op;
  logic hs, tc, unused_rsvd;
  assign hs = instr_valid && instr_ready;
  assign op = ir[OP_MSB:OP_LSB];
  assign alu_sel = op;
  assign rf_raddr_a = ir[RD_MSB:RD_LSB];
  assign rf_raddr_b = ir[RS_MSB:RS_LSB];
  assign rf_waddr = ir[RD_MSB:RD_LSB];
  assign busy = state != S_IDLE;
  assign unused_rsvd = ir[0];
  seq_timeout_ctr #(.MAX(ALU_TIMEOUT)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(state != S_WAIT),
    .en (state == S_WAIT),
    .tc (tc)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = hs ? S_DECODE : stop ? S_IDLE : S_FETCH;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = is_multi(op) ? S_WAIT : S_WB;
      S_WAIT:   nxt = alu_done ? S_WB : tc ? S_IDLE : S_WAIT;
      S_WB:     nxt = stop ? S_IDLE : S_FETCH;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      pc          <= '0;
      instr_ready <= 1'b0;
      alu_start   <= 1'b0;
      rf_we       <= 1'b0;
      flag_we     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= nxt;
      ir          <= hs ? instr : ir;
      pc          <= hs ? pc + 1'b1 : pc;
      instr_ready <= nxt == S_FETCH;
      alu_start   <= nxt == S_EXEC;
      rf_we       <= nxt == S_WB && op != OP_CMP;
      flag_we     <= nxt == S_WB && op == OP_CMP;
      err         <= (state == S_IDLE && start) ? 1'b0 : (state == S_WAIT && !alu_done && tc) ? 1'b1 : err;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized scoreboard bench for the instruction sequencer
module tb_cpu_sequencer;
  logic clk = 0, rst = 1, start = 0, stop = 0, instr_valid = 0, alu_done = 0;
  logic [7:0] instr = '0;
  logic instr_ready, rf_we, flag_we, alu_start, busy, err;
  logic [7:0] pc;
  logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [2:0] alu_sel;
  int checks = 0, errors = 0, cyc = 0, pc_m = 0;
  bit err_q = 0;
  typedef struct {int kind; int addr; int sel; int at;} exp_t;
  exp_t q[$];
  cpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .instr_valid(instr_valid),
    .instr(instr), .instr_ready(instr_ready), .pc(pc), .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we), .flag_we(flag_we),
    .alu_sel(alu_sel), .alu_start(alu_start), .alu_done(alu_done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rf_we || flag_we || alu_start) chk("one_strobe", int'(rf_we) + int'(flag_we) + int'(alu_start), 1);
    if (rf_we || flag_we || (err && !err_q)) begin
      if (q.size() == 0) chk("unexpected_event", 1, 0);
      else begin
        e = q.pop_front();
        chk("event_kind", rf_we ? 0 : flag_we ? 1 : 2, e.kind);
        chk("event_cycle", cyc, e.at);
        if (e.kind != 2) begin
          chk("wb_addr", rf_waddr, e.addr);
          chk("wb_alu_sel", alu_sel, e.sel);
        end else chk("busy_after_err", busy, 0);
      end
    end
    err_q = err;
  end
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run_instr(input logic [7:0] ins, input int d, input bit noise, input bit do_stop, input bit do_rst);
    int h, len;
    bit multi, found;
    exp_t e;
    multi = ins[7:5] == 3'd5 || ins[7:5] == 3'd6;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    instr = ins;
    instr_valid = 1;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      chk("handshake_timeout", 0, 1);
      instr_valid = 0;
      return;
    end
    h = cyc;
    chk("pc", pc, pc_m);
    pc_m = (pc_m + 1) % 256;
    e.kind = (multi && d == 0) ? 2 : (ins[7:5] == 3'd7) ? 1 : 0;
    e.addr = ins[4:3];
    e.sel = ins[7:5];
    len = !multi ? 4 : d == 0 ? 19 : 4 + d;
    e.at = h + (e.kind == 2 ? len : len - 1);
    q.push_back(e);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        instr_valid = 0;
        instr = 8'($urandom);
      end
      alu_done = (multi && d != 0 && k == 2 + d) || (noise && k == 2);
      if (do_stop && k == 2) stop = 1;
      if (do_rst && k == 4) begin
        #1 rst = 1;
        #1;
        chk("rst_outputs", int'({rf_we, flag_we, alu_start, instr_ready, busy, err, rf_waddr, rf_raddr_a, rf_raddr_b, alu_sel}), 0);
        chk("rst_pc", pc, 0);
        q.delete();
        pc_m = 0;
        alu_done = 0;
        return;
      end
    end
    alu_done = 0;
    if (do_stop || (multi && d == 0)) begin
      @(negedge clk);
      chk("idle_after", busy, 0);
      stop = 0;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      chk("err_cleared", err, 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    logic [7:0] ins;
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({rf_we, flag_we, alu_start, instr_ready, busy, err, rf_waddr, alu_sel}), 0);
    chk("reset_pc", pc, 0);
    rst = 0;
    pulse_start();
    chk("fetch_ready", instr_ready, 1);
    run_instr(8'b000_01_10_0, 0, 0, 0, 0);
    run_instr(8'b101_11_00_0, 3, 0, 0, 0);
    run_instr(8'b110_10_01_0, 0, 0, 0, 0);
    run_instr(8'b111_00_01_0, 0, 1, 0, 0);
    @(posedge clk);
    #1 stop = 1;
    @(posedge clk);
    #1;
    chk("fetch_stop_idle", int'({busy, instr_ready}), 0);
    stop = 0;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      ins = 8'($urandom);
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      run_instr(ins, d, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 0);
    end
    run_instr(8'b101_01_01_0, 10, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_rst", busy, 0);
    pulse_start();
    run_instr(8'b000_10_11_0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
